// File: rtl/bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with per-cycle bus lock.
// Optional slave watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT0 = 2'b01;
    localparam logic [1:0] GRANT1 = 2'b10;

    localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [1:0] state_q, state_d;
    // last_q: 0 = master 0 won last, 1 = master 1 won last
    logic       last_q, last_d;
    logic       rearb;
    logic       to_hit;
    logic       mux_cyc, mux_stb;

    assign rearb = (state_q == IDLE)
                || (state_q == GRANT0 && !m0_cyc_i)
                || (state_q == GRANT1 && !m1_cyc_i);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (rearb) begin
            if (m0_cyc_i && m1_cyc_i) begin
                state_d = last_q ? GRANT0 : GRANT1;
                last_d  = ~last_q;
            end else if (m0_cyc_i) begin
                state_d = GRANT0;
                last_d  = 1'b0;
            end else if (m1_cyc_i) begin
                state_d = GRANT1;
                last_d  = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = state_q;

    always_comb begin
        mux_cyc  = 1'b0;
        mux_stb  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        case (state_q)
            GRANT0: begin
                mux_cyc  = m0_cyc_i;
                mux_stb  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
            end
            GRANT1: begin
                mux_cyc  = m1_cyc_i;
                mux_stb  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
            end
            default: ;
        endcase
    end

    // A watchdog expiry pulls the strobe and fakes the slave's ack.
    assign s_cyc_o = mux_cyc & ~to_hit;
    assign s_stb_o = mux_stb & ~to_hit;

    assign m0_ack_o  = (state_q == GRANT0) & (s_ack_i | to_hit);
    assign m1_ack_o  = (state_q == GRANT1) & (s_ack_i | to_hit);
    assign m0_data_o = (state_q != GRANT0) ? '0 : (to_hit ? TO_DATA : s_data_i);
    assign m1_data_o = (state_q != GRANT1) ? '0 : (to_hit ? TO_DATA : s_data_i);

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_q;
    logic        to_flag_q;

    assign to_hit    = (state_q != IDLE) && (wd_q == TO_LIM);
    assign timeout_o = to_flag_q | to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (to_hit)
                to_flag_q <= 1'b1;
            if (state_q == IDLE || state_d != state_q || s_ack_i || to_hit)
                wd_q <= '0;
            else if (s_stb_o)
                wd_q <= wd_q + 16'd1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corners
// and a randomized run against a transaction-level owner model.
module tb_bus_arbiter;

    localparam int TO = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m0_addr_i = 0; m0_data_i = 0; m1_addr_i = 0; m1_data_i = 0;
        s_data_i = 0; s_ack_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the bus, who won last, watchdog age.
    int own, last, wcnt;
    bit sticky;

    task automatic model_reset();
        own = -1; last = 1; wcnt = 0; sticky = 0;
    endtask

    function automatic bit model_hit();
        return TO_EN && own >= 0 && wcnt == TO;
    endfunction

    task automatic model_step();
        int nxt;
        bit hit, req0, req1, rs;
        hit  = model_hit();
        req0 = m0_cyc_i;
        req1 = m1_cyc_i;
        nxt  = own;
        if (own < 0 || (own == 0 && !req0) || (own == 1 && !req1)) begin
            if (req0 && req1) nxt = 1 - last;
            else if (req0) nxt = 0;
            else if (req1) nxt = 1;
            else nxt = -1;
            if (nxt >= 0) last = nxt;
        end
        rs = (own == 0) ? m0_stb_i : (own == 1) ? m1_stb_i : 1'b0;
        if (nxt != own || own < 0 || s_ack_i || hit) wcnt = 0;
        else if (rs) wcnt++;
        if (hit) sticky = 1;
        own = nxt;
    endtask

    task automatic model_check();
        bit hit, rc, rs, rw;
        logic [31:0] ra, rd, rdata;
        hit = model_hit();
        rc = (own == 0) ? m0_cyc_i : (own == 1) ? m1_cyc_i : 1'b0;
        rs = (own == 0) ? m0_stb_i : (own == 1) ? m1_stb_i : 1'b0;
        rw = (own == 0) ? m0_we_i : (own == 1) ? m1_we_i : 1'b0;
        ra = (own == 0) ? m0_addr_i : (own == 1) ? m1_addr_i : 32'h0;
        rd = (own == 0) ? m0_data_i : (own == 1) ? m1_data_i : 32'h0;
        rdata = hit ? 32'hDEAD_BEEF : s_data_i;
        chk("rnd_grant", {30'd0, grant_o},
            (own < 0) ? 32'd0 : (own == 0) ? 32'd1 : 32'd2);
        chk("rnd_s_cyc", {31'd0, s_cyc_o}, {31'd0, rc & ~hit});
        chk("rnd_s_stb", {31'd0, s_stb_o}, {31'd0, rs & ~hit});
        chk("rnd_s_we", {31'd0, s_we_o}, {31'd0, rw});
        chk("rnd_s_addr", s_addr_o, ra);
        chk("rnd_s_wdata", s_data_o, rd);
        chk("rnd_m0_ack", {31'd0, m0_ack_o},
            {31'd0, own == 0 && (s_ack_i || hit)});
        chk("rnd_m1_ack", {31'd0, m1_ack_o},
            {31'd0, own == 1 && (s_ack_i || hit)});
        chk("rnd_m0_data", m0_data_o, (own == 0) ? rdata : 32'h0);
        chk("rnd_m1_data", m1_data_o, (own == 1) ? rdata : 32'h0);
        chk("rnd_timeout", {31'd0, timeout_o}, {31'd0, sticky | hit});
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        logic       c0;
        logic       c1;
        logic [1:0] g;
        logic       sc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] ea;
        bit c0, c1;

        tbl[0]  = '{1'b1, 1'b1, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'b01, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'b01, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'b01, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b10, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'b10, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'b10, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b0};

        reset_dut();
        @(negedge clk);
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rst_s_addr", s_addr_o, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);

        // Contention: simultaneous first request, then strict alternation.
        m0_addr_i = 32'h0000_0100;
        m1_addr_i = 32'h8000_0200;
        foreach (tbl[i]) begin
            next_cycle();
            m0_cyc_i = tbl[i].c0; m0_stb_i = tbl[i].c0;
            m1_cyc_i = tbl[i].c1; m1_stb_i = tbl[i].c1;
            @(negedge clk);
            ea = (tbl[i].g == 2'b01) ? 32'h0000_0100 :
                 (tbl[i].g == 2'b10) ? 32'h8000_0200 : 32'h0;
            chk($sformatf("tbl%0d_grant", i), {30'd0, grant_o},
                {30'd0, tbl[i].g});
            chk($sformatf("tbl%0d_s_cyc", i), {31'd0, s_cyc_o},
                {31'd0, tbl[i].sc});
            chk($sformatf("tbl%0d_s_addr", i), s_addr_o, ea);
        end

        // Single-master read with a two-cycle slave.
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
        @(negedge clk);
        chk("rd_grant_pre", {30'd0, grant_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd_grant", {30'd0, grant_o}, 32'd1);
        chk("rd_s_stb", {31'd0, s_stb_o}, 32'd1);
        chk("rd_s_addr", s_addr_o, 32'h10);
        chk("rd_ack_wait", {31'd0, m0_ack_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd_ack_wait2", {31'd0, m0_ack_o}, 32'd0);
        chk("rd_m1_ack_a", {31'd0, m1_ack_o}, 32'd0);
        next_cycle();
        s_ack_i = 1; s_data_i = 32'h1234_5678;
        @(negedge clk);
        chk("rd_ack", {31'd0, m0_ack_o}, 32'd1);
        chk("rd_data", m0_data_o, 32'h1234_5678);
        chk("rd_m1_ack_b", {31'd0, m1_ack_o}, 32'd0);
        chk("rd_m1_data", m1_data_o, 32'd0);
        next_cycle();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();
        @(negedge clk);
        chk("rd_idle", {30'd0, grant_o}, 32'd0);

        // Bus lock: m1 writes three times while m0 waits.
        next_cycle();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_addr_i = 32'h8000_0000; m1_data_i = 32'hCAFE_0001;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
            @(negedge clk);
            chk($sformatf("lock%0d_grant", k), {30'd0, grant_o}, 32'd2);
            chk($sformatf("lock%0d_m1_ack", k), {31'd0, m1_ack_o}, 32'd1);
            chk($sformatf("lock%0d_m0_ack", k), {31'd0, m0_ack_o}, 32'd0);
        end
        chk("lock_s_we", {31'd0, s_we_o}, 32'd1);
        chk("lock_s_wdata", s_data_o, 32'hCAFE_0001);
        next_cycle();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        @(negedge clk);
        chk("lock_release", {30'd0, grant_o}, 32'd2);
        next_cycle();
        @(negedge clk);
        chk("lock_handoff", {30'd0, grant_o}, 32'd1);
        next_cycle();
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();

        // Reset while m1 waits on an ack, m0 also requesting.
        next_cycle();
        m1_cyc_i = 1; m1_stb_i = 1;
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        chk("mid_grant", {30'd0, grant_o}, 32'd2);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("mid_rst_grant", {30'd0, grant_o}, 32'd0);
        chk("mid_rst_timeout", {31'd0, timeout_o}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("mid_tie_m0", {30'd0, grant_o}, 32'd1);
        next_cycle();
        clear_inputs();
        repeat (2) next_cycle();

`ifdef BUS_TIMEOUT_EN
        // Watchdog: slave never acks.
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h8000_0040;
        @(negedge clk);
        chk("to_pre_stb", {31'd0, s_stb_o}, 32'd0);
        for (int k = 0; k <= TO; k++) begin
            next_cycle();
            @(negedge clk);
            if (k < TO) begin
                chk($sformatf("to_wait%0d_ack", k), {31'd0, m0_ack_o}, 32'd0);
                chk($sformatf("to_wait%0d_stb", k), {31'd0, s_stb_o}, 32'd1);
            end else begin
                chk("to_ack", {31'd0, m0_ack_o}, 32'd1);
                chk("to_data", m0_data_o, 32'hDEAD_BEEF);
                chk("to_stb", {31'd0, s_stb_o}, 32'd0);
                chk("to_cyc", {31'd0, s_cyc_o}, 32'd0);
                chk("to_flag", {31'd0, timeout_o}, 32'd1);
            end
        end
        next_cycle();
        clear_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        chk("to_sticky", {31'd0, timeout_o}, 32'd1);
`endif

        // Randomized run against the model.
        reset_dut();
        c0 = 0; c1 = 0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            model_step();
            #1;
            if ($urandom_range(3) == 0) c0 = ~c0;
            if ($urandom_range(3) == 0) c1 = ~c1;
            m0_cyc_i = c0; m0_stb_i = c0 & $urandom_range(1);
            m1_cyc_i = c1; m1_stb_i = c1 & $urandom_range(1);
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            m0_addr_i = $urandom; m1_addr_i = $urandom;
            m0_data_i = $urandom; m1_data_i = $urandom;
            s_data_i = $urandom;
            s_ack_i = ($urandom_range(4) == 0);
            @(negedge clk);
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
